// File: rtl/decode_stage.sv
// RV32I decode stage: one _d2 register between fetch and execute, with valid/ready, stall and flush.
// Optional DECODE_ILLEGAL_TRAP_EN adds illegal_d2 and flags unknown opcodes instead of turning them into NOPs.
package proc_pkg;
  typedef enum logic [1:0] {
    ALU_ARITH     = 2'd0,
    ALU_LOGIC     = 2'd1,
    ALU_SHIFT     = 2'd2,
    ALU_PC_VAL_D2 = 2'd3
  } alu_mux_sel_t;
  typedef enum logic {OP1_REG1_DATA = 1'b0, OP1_PC_VAL_D2 = 1'b1} x_op1_mux_sel_t;
  typedef enum logic {OP2_REG2_DATA = 1'b0, OP2_IMM_SIGNED = 1'b1} x_op2_mux_sel_t;
  typedef enum logic {W_ALU = 1'b0, W_MEM = 1'b1} w_mux_sel_t;
endpackage

module decode_stage
  import proc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [31:0]     if_pc,
  output logic            id_ready,
  input  logic            ex_ready,
  input  logic            flush,
  output logic            valid_d2,
  output logic [31:0]     pc_val_d2,
  output logic [4:0]      rs1_addr_d2,
  output logic [4:0]      rs2_addr_d2,
  output logic [4:0]      rd_addr_d2,
  output logic [31:0]     imm_signed_d2,
  output logic [2:0]      alu_funct3_d2,
  output logic            alu_alt_d2,
  output alu_mux_sel_t    alu_mux_sel_d2,
  output x_op1_mux_sel_t  x_op1_mux_sel_d2,
  output x_op2_mux_sel_t  x_op2_mux_sel_d2,
  output w_mux_sel_t      w_mux_sel_d2,
  output logic            reg_we_d2
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,output logic           illegal_d2
`endif
);

  typedef struct packed {
    logic [4:0]     rs1;
    logic [4:0]     rs2;
    logic [4:0]     rd;
    logic [31:0]    imm;
    logic [2:0]     funct3;
    logic           alt;
    alu_mux_sel_t   alu;
    x_op1_mux_sel_t op1;
    x_op2_mux_sel_t op2;
    w_mux_sel_t     w;
    logic           we;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic           ill;
`endif
  } dec_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  function automatic alu_mux_sel_t alu_class(input logic [2:0] f3);
    case (f3)
      3'b001, 3'b101:         return ALU_SHIFT;
      3'b100, 3'b110, 3'b111: return ALU_LOGIC;
      default:                return ALU_ARITH;
    endcase
  endfunction

  logic [31:0] ins;
  logic [31:0] imm_i, imm_u, imm_j, imm_b;
  logic        writes_rd;
  logic        load;
  dec_t        dec, q;
  logic        valid_q;
  logic [31:0] pc_q;

  assign ins   = if_instr;
  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_u = {ins[31:12], 12'h000};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};

  // Fields an opcode doesn't use stay 0 so the _d2 bundle is deterministic.
  always_comb begin
    dec       = '0;
    dec.alu   = ALU_ARITH;
    dec.op1   = OP1_REG1_DATA;
    dec.op2   = OP2_REG2_DATA;
    dec.w     = W_ALU;
    writes_rd = 1'b0;
    case (ins[6:0])
      OPC_OP: begin
        dec.rs1    = ins[19:15];
        dec.rs2    = ins[24:20];
        dec.funct3 = ins[14:12];
        dec.alt    = ins[30];
        dec.alu    = alu_class(ins[14:12]);
        writes_rd  = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.rs1    = ins[19:15];
        dec.imm    = imm_i;
        dec.funct3 = ins[14:12];
        dec.alt    = (ins[14:12] == 3'b101) ? ins[30] : 1'b0;
        dec.alu    = alu_class(ins[14:12]);
        dec.op2    = OP2_IMM_SIGNED;
        writes_rd  = 1'b1;
      end
      OPC_LUI: begin
        dec.imm   = imm_u;
        dec.op2   = OP2_IMM_SIGNED;
        writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm   = imm_u;
        dec.op1   = OP1_PC_VAL_D2;
        dec.op2   = OP2_IMM_SIGNED;
        writes_rd = 1'b1;
      end
      OPC_JAL: begin
        dec.imm   = imm_j;
        dec.alu   = ALU_PC_VAL_D2;
        dec.op1   = OP1_PC_VAL_D2;
        dec.op2   = OP2_IMM_SIGNED;
        writes_rd = 1'b1;
      end
      OPC_JALR: begin
        dec.rs1   = ins[19:15];
        dec.imm   = imm_i;
        dec.alu   = ALU_PC_VAL_D2;
        dec.op2   = OP2_IMM_SIGNED;
        writes_rd = 1'b1;
      end
      OPC_BRANCH: begin
        // funct3 carries the compare condition to execute
        dec.rs1    = ins[19:15];
        dec.rs2    = ins[24:20];
        dec.imm    = imm_b;
        dec.funct3 = ins[14:12];
      end
      OPC_FENCE: ;
      default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        dec.ill = 1'b1;
`endif
      end
    endcase
    dec.rd = writes_rd ? ins[11:7] : 5'd0;
    dec.we = writes_rd && (ins[11:7] != 5'd0);
  end

  assign id_ready = !valid_q || ex_ready;
  assign load     = if_valid && id_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
      q       <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      pc_q    <= if_pc;
      q       <= dec;
    end else if (ex_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_d2         = valid_q;
  assign pc_val_d2        = pc_q;
  assign rs1_addr_d2      = q.rs1;
  assign rs2_addr_d2      = q.rs2;
  assign rd_addr_d2       = q.rd;
  assign imm_signed_d2    = q.imm;
  assign alu_funct3_d2    = q.funct3;
  assign alu_alt_d2       = q.alt;
  assign alu_mux_sel_d2   = q.alu;
  assign x_op1_mux_sel_d2 = q.op1;
  assign x_op2_mux_sel_d2 = q.op2;
  assign w_mux_sel_d2     = q.w;
  assign reg_we_d2        = q.we;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign illegal_d2       = q.ill;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed plan items plus randomized traffic against a spec-level model.
module tb_decode_stage;
  import proc_pkg::*;

  logic clk = 1'b0, rst_n = 1'b0;
  logic if_valid = 1'b0, ex_ready = 1'b0, flush = 1'b0;
  logic [31:0] if_instr = '0, if_pc = '0;
  logic id_ready, valid_d2, alu_alt_d2, reg_we_d2;
  logic [31:0] pc_val_d2, imm_signed_d2;
  logic [4:0] rs1_addr_d2, rs2_addr_d2, rd_addr_d2;
  logic [2:0] alu_funct3_d2;
  alu_mux_sel_t alu_mux_sel_d2;
  x_op1_mux_sel_t x_op1_mux_sel_d2;
  x_op2_mux_sel_t x_op2_mux_sel_d2;
  w_mux_sel_t w_mux_sel_d2;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_d2;
`endif

  int vecs = 0, fails = 0;

  decode_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .ex_ready(ex_ready), .flush(flush), .valid_d2(valid_d2),
    .pc_val_d2(pc_val_d2), .rs1_addr_d2(rs1_addr_d2), .rs2_addr_d2(rs2_addr_d2),
    .rd_addr_d2(rd_addr_d2), .imm_signed_d2(imm_signed_d2), .alu_funct3_d2(alu_funct3_d2),
    .alu_alt_d2(alu_alt_d2), .alu_mux_sel_d2(alu_mux_sel_d2), .x_op1_mux_sel_d2(x_op1_mux_sel_d2),
    .x_op2_mux_sel_d2(x_op2_mux_sel_d2), .w_mux_sel_d2(w_mux_sel_d2), .reg_we_d2(reg_we_d2)
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,.illegal_d2(illegal_d2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic [31:0] imm;
    logic [2:0] f3;
    logic alt, we, ill;
    alu_mux_sel_t alu;
    x_op1_mux_sel_t op1;
    x_op2_mux_sel_t op2;
  } exp_t;

  logic m_valid;
  logic [31:0] m_pc;
  exp_t m;

  // Reference decode straight from the RV32I instruction formats.
  function automatic exp_t ref_dec(input logic [31:0] w);
    exp_t e;
    logic [2:0] f3 = w[14:12];
    logic wr = 1'b0;
    logic [20:0] j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    logic [12:0] b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    alu_mux_sel_t cls = (f3 == 3'd1 || f3 == 3'd5) ? ALU_SHIFT :
                        (f3 >= 3'd4) ? ALU_LOGIC : ALU_ARITH;
    e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.imm = 0; e.f3 = 0; e.alt = 0; e.we = 0; e.ill = 0;
    e.alu = ALU_ARITH; e.op1 = OP1_REG1_DATA; e.op2 = OP2_REG2_DATA;
    case (w[6:0])
      7'b0110011: begin e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.f3 = f3; e.alt = w[30]; e.alu = cls; wr = 1; end
      7'b0010011: begin
        e.rs1 = w[19:15]; e.imm = 32'($signed(w) >>> 20); e.f3 = f3;
        e.alt = (f3 == 3'd5) && w[30]; e.alu = cls; e.op2 = OP2_IMM_SIGNED; wr = 1;
      end
      7'b0110111: begin e.imm = w & 32'hFFFF_F000; e.op2 = OP2_IMM_SIGNED; wr = 1; end
      7'b0010111: begin e.imm = w & 32'hFFFF_F000; e.op1 = OP1_PC_VAL_D2; e.op2 = OP2_IMM_SIGNED; wr = 1; end
      7'b1101111: begin
        e.imm = 32'($signed(j21)); e.alu = ALU_PC_VAL_D2; e.op1 = OP1_PC_VAL_D2; e.op2 = OP2_IMM_SIGNED; wr = 1;
      end
      7'b1100111: begin
        e.rs1 = w[19:15]; e.imm = 32'($signed(w) >>> 20); e.alu = ALU_PC_VAL_D2; e.op2 = OP2_IMM_SIGNED; wr = 1;
      end
      7'b1100011: begin e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.imm = 32'($signed(b13)); e.f3 = f3; end
      7'b0001111: ;
      default: e.ill = 1'b1;
    endcase
    e.rd = wr ? w[11:7] : 5'd0;
    e.we = wr && (w[11:7] != 0);
    return e;
  endfunction

  function automatic void mdl_reset();
    m_valid = 0; m_pc = 32'h0;
    m = ref_dec(32'h0000_000F);  // FENCE decodes to the all-default bundle
  endfunction

  // One clock of the stage as described: flush wins, else accept when ready, else drain on ex_ready.
  task automatic tick();
    logic ready = !m_valid || ex_ready;
    if (flush) m_valid = 0;
    else if (if_valid && ready) begin m_valid = 1; m_pc = if_pc; m = ref_dec(if_instr); end
    else if (ex_ready) m_valid = 0;
    @(posedge clk); #1;
  endtask

  function automatic logic [95:0] snap();
    logic il = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
    il = illegal_d2;
`endif
    return {5'b0, valid_d2, pc_val_d2, rs1_addr_d2, rs2_addr_d2, rd_addr_d2, imm_signed_d2, alu_funct3_d2,
            alu_alt_d2, alu_mux_sel_d2, x_op1_mux_sel_d2, x_op2_mux_sel_d2, w_mux_sel_d2, reg_we_d2, il};
  endfunction

  function automatic logic [95:0] msnap();
    logic il = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
    il = m.ill;
`endif
    return {5'b0, m_valid, m_pc, m.rs1, m.rs2, m.rd, m.imm, m.f3, m.alt, m.alu, m.op1, m.op2, W_ALU, m.we, il};
  endfunction

  task automatic test_reset();
    mdl_reset();
    #1;
    vecs++; if (snap() !== msnap()) begin fails++; $display("FAIL reset_state: got %h expected %h", snap(), msnap()); end
    vecs++; if (id_ready !== 1'b1) begin fails++; $display("FAIL reset_id_ready: got %b expected 1", id_ready); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_addi();
    if_valid = 1; if_instr = 32'hFFD0_8293; if_pc = 32'h40; ex_ready = 1;
    tick();
    vecs++; if (snap() !== msnap()) begin fails++; $display("FAIL addi_bundle: got %h expected %h", snap(), msnap()); end
    vecs++; if ({valid_d2, rd_addr_d2, rs1_addr_d2, imm_signed_d2, reg_we_d2} !== {1'b1, 5'd5, 5'd1, 32'hFFFF_FFFD, 1'b1})
      begin fails++; $display("FAIL addi_fields: got v=%b rd=%0d rs1=%0d imm=%h we=%b expected 1 5 1 fffffffd 1",
                              valid_d2, rd_addr_d2, rs1_addr_d2, imm_signed_d2, reg_we_d2); end
    vecs++; if (alu_mux_sel_d2 !== ALU_ARITH || x_op1_mux_sel_d2 !== OP1_REG1_DATA || x_op2_mux_sel_d2 !== OP2_IMM_SIGNED)
      begin fails++; $display("FAIL addi_sels: got %0d %0d %0d expected ARITH REG1 IMM", alu_mux_sel_d2, x_op1_mux_sel_d2, x_op2_mux_sel_d2); end
    if_valid = 0;
    tick();
    vecs++; if (snap() !== msnap()) begin fails++; $display("FAIL drain: got %h expected %h", snap(), msnap()); end
  endtask

  task automatic test_auipc_jal();
    if_valid = 1; if_instr = 32'h1234_5117; if_pc = 32'h100; ex_ready = 1;
    tick();
    vecs++; if ({x_op1_mux_sel_d2, imm_signed_d2, pc_val_d2} !== {OP1_PC_VAL_D2, 32'h1234_5000, 32'h100})
      begin fails++; $display("FAIL auipc: got op1=%0d imm=%h pc=%h expected 1 12345000 100", x_op1_mux_sel_d2, imm_signed_d2, pc_val_d2); end
    vecs++; if (snap() !== msnap()) begin fails++; $display("FAIL auipc_bundle: got %h expected %h", snap(), msnap()); end
    if_instr = 32'h0080_00EF; if_pc = 32'h104;
    tick();
    vecs++; if (alu_mux_sel_d2 !== ALU_PC_VAL_D2 || imm_signed_d2 !== 32'd8 || valid_d2 !== 1'b1)
      begin fails++; $display("FAIL jal: got alu=%0d imm=%h v=%b expected 3 00000008 1", alu_mux_sel_d2, imm_signed_d2, valid_d2); end
    vecs++; if (snap() !== msnap()) begin fails++; $display("FAIL jal_bundle: got %h expected %h", snap(), msnap()); end
  endtask

  task automatic test_stall();
    if_valid = 1; if_instr = 32'h4020_81B3; if_pc = 32'h200; ex_ready = 1;
    tick();
    ex_ready = 0; if_instr = 32'h0070_0313; if_pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++; if (id_ready !== 1'b0) begin fails++; $display("FAIL stall_ready[%0d]: got %b expected 0", i, id_ready); end
      tick();
      vecs++; if (snap() !== msnap() || alu_alt_d2 !== 1'b1 || rd_addr_d2 !== 5'd3)
        begin fails++; $display("FAIL stall_hold[%0d]: got %h expected %h (alt=%b rd=%0d)", i, snap(), msnap(), alu_alt_d2, rd_addr_d2); end
    end
    ex_ready = 1;
    tick();
    vecs++; if (valid_d2 !== 1'b1 || rd_addr_d2 !== 5'd6 || pc_val_d2 !== 32'h204)
      begin fails++; $display("FAIL stall_release: got v=%b rd=%0d pc=%h expected 1 6 204", valid_d2, rd_addr_d2, pc_val_d2); end
    vecs++; if (snap() !== msnap()) begin fails++; $display("FAIL release_bundle: got %h expected %h", snap(), msnap()); end
  endtask

  task automatic test_flush();
    if_valid = 1; if_instr = 32'h0010_0093; if_pc = 32'h300; ex_ready = 0; flush = 1;
    tick();
    flush = 0; if_valid = 0; ex_ready = 1;
    vecs++; if (valid_d2 !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b expected 0", valid_d2); end
    vecs++; if (snap() !== msnap()) begin fails++; $display("FAIL flush_bundle: got %h expected %h", snap(), msnap()); end
  endtask

  task automatic test_illegal();
    if_valid = 1; if_instr = 32'h0; if_pc = 32'h400; ex_ready = 1;
    tick();
    if_valid = 0;
    vecs++; if (valid_d2 !== 1'b1 || reg_we_d2 !== 1'b0)
      begin fails++; $display("FAIL illegal_load: got v=%b we=%b expected 1 0", valid_d2, reg_we_d2); end
`ifdef DECODE_ILLEGAL_TRAP_EN
    vecs++; if (illegal_d2 !== 1'b1) begin fails++; $display("FAIL illegal_flag: got %b expected 1", illegal_d2); end
`endif
    vecs++; if (snap() !== msnap()) begin fails++; $display("FAIL illegal_bundle: got %h expected %h", snap(), msnap()); end
  endtask

  task automatic test_random();
    logic [6:0] opcs [10] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                              7'b1100111, 7'b1100011, 7'b0001111, 7'b0000011, 7'b1111111};
    for (int i = 0; i < 400; i++) begin
      if_valid = $urandom_range(0, 3) != 0;
      ex_ready = $urandom_range(0, 3) != 0;
      flush    = $urandom_range(0, 15) == 0;
      if_instr = ($urandom() & 32'hFFFF_FF80) | {25'b0, opcs[$urandom_range(0, 9)]};
      if_pc    = $urandom() & 32'hFFFF_FFFC;
      #1;
      vecs++; if (id_ready !== (!m_valid || ex_ready))
        begin fails++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, id_ready, !m_valid || ex_ready); end
      tick();
      vecs++; if (snap() !== msnap()) begin fails++; $display("FAIL rand_bundle[%0d] instr=%h: got %h expected %h", i, if_instr, snap(), msnap()); end
    end
    flush = 0;
  endtask

  task automatic test_reset_midstall();
    if_valid = 1; if_instr = 32'h0020_81B3; if_pc = 32'h500; ex_ready = 1;
    tick();
    ex_ready = 0;
    tick();
    #2 rst_n = 0;
    mdl_reset();
    #1;
    vecs++; if (snap() !== msnap()) begin fails++; $display("FAIL async_reset: got %h expected %h", snap(), msnap()); end
    vecs++; if (id_ready !== 1'b1) begin fails++; $display("FAIL async_reset_ready: got %b expected 1", id_ready); end
    @(negedge clk);
    rst_n = 1; ex_ready = 1; if_instr = 32'hFFD0_8293; if_pc = 32'h600;
    tick();
    vecs++; if (snap() !== msnap()) begin fails++; $display("FAIL post_reset_load: got %h expected %h", snap(), msnap()); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_auipc_jal();
    test_stall();
    test_flush();
    test_illegal();
    test_random();
    test_reset_midstall();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Second pipeline stage of the core: accepts fetched instructions from fetch and holds them in a single stage register. Decodes each RV32I instruction into the execute-stage mux selects (`alu_mux_sel_t`, `x_op1_mux_sel_t`, `x_op2_mux_sel_t`, `w_mux_sel_t` from `proc_pkg`), register addresses, a sign-extended immediate and ALU sub-op fields. Presents them to execute as the `_d2` stage with a valid/ready handshake, stall and flush.

## Interface
- `RESET_PC`, 32'h0000_0000, value of `pc_val_d2` after reset
- `clk` in 1: core clock, all state on rising edge
- `rst_n` in 1: asynchronous active-low reset
- `if_valid` in 1: fetch presents an instruction
- `if_instr` in 32: instruction word
- `if_pc` in 32: PC of `if_instr`
- `id_ready` out 1: decode accepts this cycle
- `ex_ready` in 1: execute accepts the `_d2` contents this cycle
- `flush` in 1: squash held and incoming instruction (redirect)
- `valid_d2` out 1: `_d2` outputs hold a live instruction
- `pc_val_d2` out 32: PC of held instruction
- `rs1_addr_d2`, `rs2_addr_d2`, `rd_addr_d2` out 5 each: register addresses
- `imm_signed_d2` out 32: sign-extended immediate
- `alu_funct3_d2` out 3: funct3 for ARITH/LOGIC/SHIFT units
- `alu_alt_d2` out 1: funct7[5] (SUB/SRA), forced 0 for OP-IMM except shifts
- `alu_mux_sel_d2` out `alu_mux_sel_t`
- `x_op1_mux_sel_d2` out `x_op1_mux_sel_t`
- `x_op2_mux_sel_d2` out `x_op2_mux_sel_t`
- `w_mux_sel_d2` out `w_mux_sel_t`
- `reg_we_d2` out 1: instruction writes `rd` (0 when `rd`==0)
- `illegal_d2` out 1: held instruction is illegal (present only with `DECODE_ILLEGAL_TRAP_EN`)

## Operation
- `id_ready` = `!valid_d2 || ex_ready`, purely combinational, independent of `if_valid`.
- Load: when `if_valid && id_ready && !flush`, all `_d2` registers capture the decode of `if_instr`/`if_pc` and `valid_d2` is set to 1.
- Drain: when `ex_ready && valid_d2` and no new load occurs, `valid_d2` is cleared. Data registers hold their values.
- Stall: when `valid_d2 && !ex_ready`, all `_d2` registers hold.
- Flush: it dominates everything; `valid_d2` is cleared next cycle, and an instruction offered in the same cycle is dropped.
- Decode by opcode:
  - OP (0110011): op1=REG1_DATA, op2=REG2_DATA. ALU sel is ARITH (funct3 000/010/011), SHIFT (001/101) or LOGIC (100/110/111).
  - OP-IMM (0010011): same as OP with op2=IMM_SIGNED and I-type immediate. `alu_alt_d2`=funct7[5] only for funct3 101.
  - LUI: `rs1_addr_d2` forced 0, op1=REG1_DATA, op2=IMM_SIGNED, ARITH, funct3 000, U-type immediate.
  - AUIPC: op1=PC_VAL_D2, op2=IMM_SIGNED, ARITH, U-type immediate.
  - JAL/JALR: alu sel ALU_PC_VAL_D2 (link = pc+4 in execute). Immediate is J-type or I-type.
  - BRANCH: B-type immediate, op1=REG1_DATA, op2=REG2_DATA, ARITH, `reg_we_d2`=0.
  - FENCE: NOP (`reg_we_d2`=0).
  - All others: illegal.
- `w_mux_sel_d2` is always ALU. `reg_we_d2` = writes-rd && `rd`!=0.
- Unused immediate bits are 0 for R-type.

## Timing
- Latency 1 cycle from accepted `if_instr` to `valid_d2`. Throughput 1 instruction/cycle with `ex_ready` held high.
- Reset values (async, immediate on `rst_n` low):
  - `valid_d2`=0, `pc_val_d2`=`RESET_PC`, all addresses/imm/funct=0, `reg_we_d2`=0, `illegal_d2`=0.
  - Sels: ARITH, REG1_DATA, REG2_DATA, ALU.
  - `id_ready`=1.
- Reset deasserted mid-stream: the first acceptance is on the first rising edge with `rst_n` high.
- Simultaneous drain and load: the new instruction replaces the old in one cycle with no bubble.

## Configuration
- `DECODE_ILLEGAL_TRAP_EN` defined: illegal opcodes load with `valid_d2`=1, `illegal_d2`=1, `reg_we_d2`=0. Execute owns the trap.
- Undefined: `illegal_d2` port absent. Illegal opcodes load as NOP (`valid_d2`=1, `reg_we_d2`=0, default sels).

## Test plan
- `addi x5,x1,-3` (0xFFD08293) with `ex_ready`=1 -> next cycle `valid_d2`=1, `rd`=5, `rs1`=1, `imm`=0xFFFFFFFD, ARITH, REG1_DATA, IMM_SIGNED, `reg_we`=1.
- `auipc x2,0x12345` at pc 0x100 -> op1=PC_VAL_D2, `imm`=0x12345000, `pc_val_d2`=0x100. Then `jal x1,+8` -> ALU_PC_VAL_D2, `imm`=8.
- Stall: load `sub x3,x1,x2`, hold `ex_ready`=0 for 3 cycles while fetch offers a new word -> `id_ready`=0, `_d2` unchanged, `alu_alt_d2`=1. Release `ex_ready` -> the new word loads next cycle with no bubble.
- Flush with `if_valid`=1 and `valid_d2`=1 -> next cycle `valid_d2`=0 and the offered word is discarded.
- Illegal 0x00000000 -> with macro: `illegal_d2`=1, `reg_we_d2`=0. Without macro: NOP, `reg_we_d2`=0.
- `rst_n` low during a stalled instruction -> `valid_d2`=0 and all `_d2` outputs at reset values before the next clock edge.
